// File: rtl/alu_defs_pkg.sv
// Shared definitions for the Alu sequencer: opcode constants, FSM state
// encoding and the default datapath width.
package alu_defs;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] ALU_OR   = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_MUL  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SHL1 = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins, a conflict is
// resolved by the pointer. Purely combinational; the pointer lives in the parent.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    assign grant_o[0] = valid_i[0] & (~valid_i[1] | ~ptr_i);
    assign grant_o[1] = valid_i[1] & (~valid_i[0] |  ptr_i);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational Alu between two requesters: round-robin accept,
// multicycle hold for multiply, registered response with backpressure.
module alu_arbiter
    import alu_defs::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_sel0,
    input  logic [2:0]       req_sel1,
    input  logic [WIDTH-1:0] req_op1_0,
    input  logic [WIDTH-1:0] req_op2_0,
    input  logic [WIDTH-1:0] req_op1_1,
    input  logic [WIDTH-1:0] req_op2_1,
    output logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zflag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zflag,
    output logic             busy
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0]   alu_op1_q, alu_op1_d;
    logic [WIDTH-1:0]   alu_op2_q, alu_op2_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_zflag_q, rsp_zflag_d;

    logic [1:0]         grant;
    logic [2:0]         sel_in;
    logic [WIDTH-1:0]   op1_in;
    logic [WIDTH-1:0]   op2_in;

    rr_arb2 u_rr_arb2 (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Grants are only offered while idle, so a high grant bit in IDLE is a transfer.
    assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;

    assign sel_in = grant[1] ? req_sel1  : req_sel0;
    assign op1_in = grant[1] ? req_op1_1 : req_op1_0;
    assign op2_in = grant[1] ? req_op2_1 : req_op2_0;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        alu_sel_d    = alu_sel_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zflag_d  = rsp_zflag_q;

        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    alu_sel_d = sel_in;
                    alu_op1_d = op1_in;
                    alu_op2_d = op2_in;
                    rsp_id_d  = grant[1];
                    ptr_d     = ~grant[1];
                    cnt_d     = (sel_in == ALU_MUL) ? MUL_LOAD : '0;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_result_d = alu_result;
                    rsp_zflag_d  = alu_zflag;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset discards any in-flight op; alu_* otherwise keep the last op after completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            cnt_q        <= '0;
            alu_sel_q    <= 3'b000;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zflag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            alu_sel_q    <= alu_sel_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zflag_q  <= rsp_zflag_d;
        end
    end

    assign alu_sel    = alu_sel_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zflag  = rsp_zflag_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written backpressure and
// reset sequences, then randomized traffic against a behavioural model.
module tb_alu_arbiter;

    localparam int MUL_CYCLES = 2;

    logic        clk;
    logic        reset;
    logic [1:0]  reqValid;
    logic [1:0]  req_ready;
    logic [2:0]  sel0, sel1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  alu_sel;
    logic [31:0] alu_op1, alu_op2;
    logic [31:0] alu_result;
    logic        alu_zflag;
    logic        rsp_valid;
    logic        rspReady;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zflag;
    logic        busy;

    int   nVec = 0;
    int   nErr = 0;
    logic ptrModel = 1'b0;
    logic [2:0] lastSel = 3'b000;
    bit   hadPrev = 0;

    typedef struct packed {
        logic [1:0]  valid;
        logic [2:0]  s0;
        logic [31:0] x0;
        logic [31:0] y0;
        logic [2:0]  s1;
        logic [31:0] x1;
        logic [31:0] y1;
        logic        firstId;
        logic [31:0] res0;
        logic        z0;
        logic [31:0] res1;
        logic        z1;
    } vec_t;

    vec_t vecs [9];

    alu_arbiter #(.WIDTH(32), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (reqValid),
        .req_ready  (req_ready),
        .req_sel0   (sel0),
        .req_sel1   (sel1),
        .req_op1_0  (a0),
        .req_op2_0  (b0),
        .req_op1_1  (a1),
        .req_op2_1  (b1),
        .alu_sel    (alu_sel),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result),
        .alu_zflag  (alu_zflag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rspReady),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zflag  (rsp_zflag),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] aluRef(input logic [2:0] s, input logic [31:0] x, input logic [31:0] y);
        case (s)
            3'b000:  return x | y;
            3'b001:  return x + y;
            3'b010:  return x * y;
            3'b011:  return x ^ y;
            3'b100:  return x - y;
            3'b101:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b110:  return y << 1;
            default: return x & y;
        endcase
    endfunction

    // Stand-in for the datapath's combinational Alu.
    always_comb begin
        alu_result = aluRef(alu_sel, alu_op1, alu_op2);
        alu_zflag  = (alu_result == 32'd0);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        sel0 = v.s0; a0 = v.x0; b0 = v.y0;
        sel1 = v.s1; a1 = v.x1; b1 = v.y1;
        reqValid = v.valid;
    endtask

    // Waits for the expected grant, follows the op to its response and retires it.
    task automatic complete(input logic expId, input logic [31:0] expRes, input logic expZ,
                            input int holdCycles, input bit pendOther);
        logic [2:0]  s;
        logic [31:0] x, y;
        int waitCnt, lat, expLat;
        bit granted, got;
        s = expId ? sel1 : sel0;
        x = expId ? a1 : a0;
        y = expId ? b1 : b0;
        expLat = (s == 3'b010) ? 1 + MUL_CYCLES : 2;
        waitCnt = 0;
        granted = 0;
        while (!granted && waitCnt < 20) begin
            @(negedge clk);
            if ((req_ready & reqValid) != 2'b00) granted = 1;
            else waitCnt++;
        end
        checkOutput("grantSeen", 32'(granted), 32'd1);
        if (!granted) begin
            reqValid[expId] = 1'b0;
            ptrModel = ~expId;
            return;
        end
        checkOutput("grantWait", 32'(waitCnt), 32'd0);
        checkOutput("reqReady", 32'(req_ready), expId ? 32'd2 : 32'd1);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleRspValid", 32'(rsp_valid), 32'd0);
        if (hadPrev) checkOutput("aluSelRetained", 32'(alu_sel), 32'(lastSel));
        rspReady = (holdCycles == 0);
        @(posedge clk); #1;
        reqValid[expId] = 1'b0;
        if (pendOther) reqValid[~expId] = 1'b1;
        ptrModel = ~expId;
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1;
            end else begin
                checkOutput("execAluSel", 32'(alu_sel), 32'(s));
                checkOutput("execAluOp1", alu_op1, x);
                checkOutput("execAluOp2", alu_op2, y);
                checkOutput("execBusy", 32'(busy), 32'd1);
                checkOutput("execReqReady", 32'(req_ready), 32'd0);
            end
        end
        checkOutput("rspSeen", 32'(got), 32'd1);
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("rspId", 32'(rsp_id), 32'(expId));
        checkOutput("rspResult", rsp_result, expRes);
        checkOutput("rspZflag", 32'(rsp_zflag), 32'(expZ));
        checkOutput("respBusy", 32'(busy), 32'd1);
        checkOutput("respReqReady", 32'(req_ready), 32'd0);
        checkOutput("respAluSel", 32'(alu_sel), 32'(s));
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput("holdRspValid", 32'(rsp_valid), 32'd1);
            checkOutput("holdRspResult", rsp_result, expRes);
            checkOutput("holdReqReady", 32'(req_ready), 32'd0);
        end
        if (holdCycles > 0) begin
            rspReady = 1'b1;
            #1;
            checkOutput("handshakeReqReady", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        lastSel = s;
        hadPrev = 1;
    endtask

    task automatic runVector(input vec_t v, input int holdCycles);
        applyStimulus(v);
        complete(v.firstId, v.res0, v.z0, holdCycles, 1'b0);
        if (v.valid == 2'b11) complete(~v.firstId, v.res1, v.z1, 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       w;
        logic [31:0] r;
        reset = 1'b1;
        reqValid = 2'b00;
        rspReady = 1'b1;
        sel0 = 3'b000; sel1 = 3'b000;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;

        //             valid  s0      x0             y0             s1      x1             y1           id    res0           z0    res1    z1
        vecs[0] = '{2'b01, 3'b001, 32'd5,         32'd7,         3'b000, 32'd0,         32'd0,         1'b0, 32'd12,        1'b0, 32'd0,  1'b0};
        vecs[1] = '{2'b10, 3'b000, 32'd0,         32'd0,         3'b100, 32'd9,         32'd9,         1'b1, 32'd0,         1'b1, 32'd0,  1'b0};
        vecs[2] = '{2'b11, 3'b001, 32'd1,         32'd1,         3'b000, 32'd4,         32'd2,         1'b0, 32'd2,         1'b0, 32'd6,  1'b0};
        vecs[3] = '{2'b11, 3'b001, 32'd1,         32'd1,         3'b000, 32'd4,         32'd2,         1'b0, 32'd2,         1'b0, 32'd6,  1'b0};
        vecs[4] = '{2'b01, 3'b010, 32'd3,         32'd4,         3'b000, 32'd0,         32'd0,         1'b0, 32'd12,        1'b0, 32'd0,  1'b0};
        vecs[5] = '{2'b10, 3'b000, 32'd0,         32'd0,         3'b110, 32'h1234,      32'h8000_0000, 1'b1, 32'd0,         1'b1, 32'd0,  1'b0};
        vecs[6] = '{2'b11, 3'b111, 32'hFF00,      32'h0FF0,      3'b101, 32'd1,         32'd2,         1'b0, 32'h0F00,      1'b0, 32'd1,  1'b0};
        vecs[7] = '{2'b01, 3'b100, 32'd3,         32'd5,         3'b000, 32'd0,         32'd0,         1'b0, 32'hFFFF_FFFE, 1'b0, 32'd0,  1'b0};
        vecs[8] = '{2'b11, 3'b001, 32'hFFFF_FFFF, 32'd1,         3'b010, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0,         1'b1, 32'd0,  1'b1};

        #3;
        checkOutput("resetReqReady", 32'(req_ready), 32'd0);
        checkOutput("resetAluSel", 32'(alu_sel), 32'd0);
        checkOutput("resetAluOp1", alu_op1, 32'd0);
        checkOutput("resetAluOp2", alu_op2, 32'd0);
        checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("resetRspId", 32'(rsp_id), 32'd0);
        checkOutput("resetRspResult", rsp_result, 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) runVector(vecs[i], 0);

        // Backpressure: XOR held four extra cycles while requester 1 waits.
        sel0 = 3'b011; a0 = 32'hF0; b0 = 32'h0F;
        sel1 = 3'b001; a1 = 32'd2;  b1 = 32'd3;
        reqValid = 2'b01;
        complete(1'b0, 32'hFF, 1'b0, 4, 1'b1);
        complete(1'b1, 32'd5, 1'b0, 0, 1'b0);

        // Reset in the middle of a multiply from requester 0.
        sel0 = 3'b010; a0 = 32'd6; b0 = 32'd7;
        reqValid = 2'b01;
        @(negedge clk);
        checkOutput("preResetGrant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        reqValid = 2'b00;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        checkOutput("midResetRspValid", 32'(rsp_valid), 32'd0);
        checkOutput("midResetAluSel", 32'(alu_sel), 32'd0);
        checkOutput("midResetAluOp1", alu_op1, 32'd0);
        checkOutput("midResetAluOp2", alu_op2, 32'd0);
        checkOutput("midResetRspResult", rsp_result, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ptrModel = 1'b0;
        lastSel = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("postResetRspValid", 32'(rsp_valid), 32'd0);
            checkOutput("postResetBusy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        runVector('{2'b11, 3'b001, 32'd10, 32'd20, 3'b011, 32'd5, 32'd5,
                    1'b0, 32'd30, 1'b0, 32'd0, 1'b1}, 0);

        // Randomized traffic against the behavioural model.
        for (int i = 0; i < 60; i++) begin
            sel0 = 3'($urandom_range(0, 7));
            sel1 = 3'($urandom_range(0, 7));
            a0 = $urandom; b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            a1 = $urandom; b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a0 = a0 & 32'hFF; b0 = b0 & 32'hFF;
            end
            reqValid = 2'($urandom_range(1, 3));
            while (reqValid != 2'b00) begin
                w = (reqValid == 2'b11) ? ptrModel : reqValid[1];
                r = w ? aluRef(sel1, a1, b1) : aluRef(sel0, a0, b0);
                complete(w, r, (r == 32'd0), $urandom_range(0, 2), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
